// File: rtl/ysyx_24080006_wbu_if.sv
// Handshake bundle around the write-back stage: LSU payload in, next PC out to the IFU.
// The slave modport is the WBU side; the master modport is the surrounding pipeline.
interface ysyx_24080006_wbu_if;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] dnpc;
      logic [4:0]  rd_addr;
      logic        wb;
      logic [31:0] alu_res;
      logic [11:0] csr_addr;
      logic        csr_we;
      logic [31:0] csr_wdata;
      logic        ecall;
   } stage_t;

   stage_t      lsu2wbu;
   logic        wbu2lsu_ready;
   logic        wbu2ifu_valid;
   logic [31:0] wbu2ifu_npc;
   logic        ifu2wbu_ready;

   modport master (
      output lsu2wbu,
      output ifu2wbu_ready,
      input  wbu2lsu_ready,
      input  wbu2ifu_valid,
      input  wbu2ifu_npc
   );

   modport slave (
      input  lsu2wbu,
      input  ifu2wbu_ready,
      output wbu2lsu_ready,
      output wbu2ifu_valid,
      output wbu2ifu_npc
   );
endinterface

// File: rtl/ysyx_24080006_wbu.sv
// Write-back/commit stage: owns the GPR file and M-mode CSRs, commits one instruction at a time.
// Define WBU_RVE_EN for a 16-entry (RV32E) register file.
module ysyx_24080006_wbu #(
   parameter logic [31:0] RESET_PC  = 32'h3000_0000,
   parameter logic [31:0] MVENDORID = 32'h7973_7978,
   parameter logic [31:0] MARCHID   = 32'h016F_6E86
) (
   input  logic                      clock,
   input  logic                      reset,
   ysyx_24080006_wbu_if.slave        bus,
   input  logic [4:0]                rs1_addr,
   input  logic [4:0]                rs2_addr,
   output logic [31:0]               rs1_data,
   output logic [31:0]               rs2_data,
   input  logic [11:0]               csr_raddr,
   output logic [31:0]               csr_rdata
);

`ifdef WBU_RVE_EN
   localparam int unsigned GprAw = 4;
`else
   localparam int unsigned GprAw = 5;
`endif
   localparam int unsigned NumGpr = 1 << GprAw;

   localparam logic [11:0] CsrMstatus   = 12'h300;
   localparam logic [11:0] CsrMtvec     = 12'h305;
   localparam logic [11:0] CsrMepc      = 12'h341;
   localparam logic [11:0] CsrMcause    = 12'h342;
   localparam logic [11:0] CsrMcycle    = 12'hB00;
   localparam logic [11:0] CsrMinstret  = 12'hB02;
   localparam logic [11:0] CsrMvendorid = 12'hF11;
   localparam logic [11:0] CsrMarchid   = 12'hF12;

   typedef enum logic [1:0] {StIdle, StCommit, StWait} state_e;

   state_e      state_q;
   logic        ready_q;
   logic        valid_q;
   logic [31:0] npc_q;

   logic [31:0] pc_q;
   logic [31:0] dnpc_q;
   logic [4:0]  rd_q;
   logic        wb_q;
   logic [31:0] alu_q;
   logic [11:0] csr_addr_q;
   logic        csr_we_q;
   logic [31:0] csr_wdata_q;
   logic        ecall_q;

   logic [31:0] gpr_q [NumGpr];
   logic [31:0] mstatus_q;
   logic [31:0] mtvec_q;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mcycle_q;
   logic [31:0] minstret_q;

   logic             gpr_we;
   logic [GprAw-1:0] gpr_widx;
   logic             rs1_hi;
   logic             rs2_hi;

`ifdef WBU_RVE_EN
   // Upper half of the 5-bit address space does not exist in RV32E.
   assign gpr_we = wb_q && !rd_q[4] && (rd_q[3:0] != 4'd0);
   assign rs1_hi = rs1_addr[4];
   assign rs2_hi = rs2_addr[4];
`else
   assign gpr_we = wb_q && (rd_q != 5'd0);
   assign rs1_hi = 1'b0;
   assign rs2_hi = 1'b0;
`endif
   assign gpr_widx = rd_q[GprAw-1:0];

   assign rs1_data = (rs1_hi || rs1_addr == 5'd0) ? 32'd0 : gpr_q[rs1_addr[GprAw-1:0]];
   assign rs2_data = (rs2_hi || rs2_addr == 5'd0) ? 32'd0 : gpr_q[rs2_addr[GprAw-1:0]];

   always_comb begin
      csr_rdata = 32'd0;
      case (csr_raddr)
         CsrMstatus:   csr_rdata = mstatus_q;
         CsrMtvec:     csr_rdata = mtvec_q;
         CsrMepc:      csr_rdata = mepc_q;
         CsrMcause:    csr_rdata = mcause_q;
         CsrMcycle:    csr_rdata = mcycle_q;
         CsrMinstret:  csr_rdata = minstret_q;
         CsrMvendorid: csr_rdata = MVENDORID;
         CsrMarchid:   csr_rdata = MARCHID;
         default:      csr_rdata = 32'd0;
      endcase
   end

   assign bus.wbu2lsu_ready = ready_q;
   assign bus.wbu2ifu_valid = valid_q;
   assign bus.wbu2ifu_npc   = npc_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
         npc_q       <= RESET_PC;
         pc_q        <= 32'd0;
         dnpc_q      <= 32'd0;
         rd_q        <= 5'd0;
         wb_q        <= 1'b0;
         alu_q       <= 32'd0;
         csr_addr_q  <= 12'd0;
         csr_we_q    <= 1'b0;
         csr_wdata_q <= 32'd0;
         ecall_q     <= 1'b0;
         for (int i = 0; i < NumGpr; i++) gpr_q[i] <= 32'd0;
         mstatus_q   <= 32'h0000_1800;
         mtvec_q     <= 32'd0;
         mepc_q      <= 32'd0;
         mcause_q    <= 32'd0;
         mcycle_q    <= 32'd0;
         minstret_q  <= 32'd0;
      end else begin
         mcycle_q <= mcycle_q + 32'd1;
         unique case (state_q)
            StIdle: begin
               if (bus.lsu2wbu.valid) begin
                  pc_q        <= bus.lsu2wbu.pc;
                  dnpc_q      <= bus.lsu2wbu.dnpc;
                  rd_q        <= bus.lsu2wbu.rd_addr;
                  wb_q        <= bus.lsu2wbu.wb;
                  alu_q       <= bus.lsu2wbu.alu_res;
                  csr_addr_q  <= bus.lsu2wbu.csr_addr;
                  csr_we_q    <= bus.lsu2wbu.csr_we;
                  csr_wdata_q <= bus.lsu2wbu.csr_wdata;
                  ecall_q     <= bus.lsu2wbu.ecall;
                  ready_q     <= 1'b0;
                  state_q     <= StCommit;
               end
            end
            StCommit: begin
               if (gpr_we) gpr_q[gpr_widx] <= alu_q;
               minstret_q <= minstret_q + 32'd1;
               // Later assignments win: explicit CSR writes override counters, traps override both.
               if (csr_we_q) begin
                  case (csr_addr_q)
                     CsrMstatus:  mstatus_q  <= csr_wdata_q;
                     CsrMtvec:    mtvec_q    <= csr_wdata_q;
                     CsrMepc:     mepc_q     <= csr_wdata_q;
                     CsrMcause:   mcause_q   <= csr_wdata_q;
                     CsrMcycle:   mcycle_q   <= csr_wdata_q;
                     CsrMinstret: minstret_q <= csr_wdata_q;
                     default:     ;
                  endcase
               end
               if (ecall_q) begin
                  mepc_q   <= pc_q;
                  mcause_q <= 32'd11;
               end
               npc_q   <= ecall_q ? mtvec_q : dnpc_q;
               valid_q <= 1'b1;
               state_q <= StWait;
            end
            StWait: begin
               if (bus.ifu2wbu_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_wbu.sv
// Bench for the write-back stage: directed cases with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the architectural state.
module tb_ysyx_24080006_wbu;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rs1_addr = 5'd0;
   logic [4:0]  rs2_addr = 5'd0;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [11:0] csr_raddr = 12'd0;
   logic [31:0] csr_rdata;

   ysyx_24080006_wbu_if bus ();

   ysyx_24080006_wbu dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .csr_raddr (csr_raddr),
      .csr_rdata (csr_rdata)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural model: state updated once per retired instruction.
   logic [31:0] m_gpr [32];
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mcycle, m_minstret, m_npc;
   bit          m_busy, m_committed, started;
   logic [31:0] p_pc, p_dnpc, p_alu, p_cwd;
   logic [4:0]  p_rd;
   logic [11:0] p_ca;
   logic        p_wb, p_cwe, p_ecall;

   function automatic logic [31:0] m_gpr_read(input logic [4:0] a);
`ifdef WBU_RVE_EN
      if (a >= 5'd16) return 32'd0;
`endif
      if (a == 5'd0) return 32'd0;
      return m_gpr[a];
   endfunction

   function automatic logic [31:0] m_csr_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'hB00: return m_mcycle;
         12'hB02: return m_minstret;
         12'hF11: return 32'h7973_7978;
         12'hF12: return 32'h016F_6E86;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_retire();
      logic [31:0] old_mtvec;
      bit          rd_ok;
      old_mtvec = m_mtvec;
      rd_ok = (p_rd != 5'd0);
`ifdef WBU_RVE_EN
      rd_ok = rd_ok && (p_rd < 5'd16);
`endif
      if (p_wb && rd_ok) m_gpr[p_rd] = p_alu;
      m_minstret = m_minstret + 32'd1;
      if (p_cwe) begin
         case (p_ca)
            12'h300: m_mstatus  = p_cwd;
            12'h305: m_mtvec    = p_cwd;
            12'h341: m_mepc     = p_cwd;
            12'h342: m_mcause   = p_cwd;
            12'hB00: m_mcycle   = p_cwd;
            12'hB02: m_minstret = p_cwd;
            default: ;
         endcase
      end
      if (p_ecall) begin
         m_mepc   = p_pc;
         m_mcause = 32'd11;
      end
      m_npc = p_ecall ? old_mtvec : p_dnpc;
   endtask

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
         m_mstatus = 32'h1800; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
         m_mcycle = 0; m_minstret = 0; m_npc = 32'h3000_0000;
         m_busy = 0; m_committed = 0; started = 1;
      end else if (started) begin
         m_mcycle = m_mcycle + 32'd1;
         if (!m_busy) begin
            if (bus.lsu2wbu.valid) begin
               p_pc = bus.lsu2wbu.pc; p_dnpc = bus.lsu2wbu.dnpc; p_rd = bus.lsu2wbu.rd_addr;
               p_wb = bus.lsu2wbu.wb; p_alu = bus.lsu2wbu.alu_res; p_ca = bus.lsu2wbu.csr_addr;
               p_cwe = bus.lsu2wbu.csr_we; p_cwd = bus.lsu2wbu.csr_wdata;
               p_ecall = bus.lsu2wbu.ecall;
               m_busy = 1; m_committed = 0;
            end
         end else if (!m_committed) begin
            m_retire();
            m_committed = 1;
         end else if (bus.ifu2wbu_ready) begin
            m_busy = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (started && !reset) begin
         chk("lsu_ready", 32'(bus.wbu2lsu_ready), 32'(!m_busy));
         chk("ifu_valid", 32'(bus.wbu2ifu_valid), 32'(m_busy && m_committed));
         chk("ifu_npc", bus.wbu2ifu_npc, m_npc);
         chk("rs1_data", rs1_data, m_gpr_read(rs1_addr));
         chk("rs2_data", rs2_data, m_gpr_read(rs2_addr));
         chk("csr_rdata", csr_rdata, m_csr_read(csr_raddr));
      end
   end

   bit rnd = 0;

   function automatic logic [11:0] pick_csr();
      case ($urandom % 10)
         0: return 12'h300;
         1: return 12'h305;
         2: return 12'h341;
         3: return 12'h342;
         4: return 12'hB00;
         5: return 12'hB02;
         6: return 12'hF11;
         7: return 12'hF12;
         8: return 12'h344;
         default: return 12'($urandom);
      endcase
   endfunction

   task automatic step();
      @(negedge clock);
      #1;
      if (rnd) begin
         bus.lsu2wbu.valid     = ($urandom % 3) == 0;
         bus.lsu2wbu.pc        = $urandom & 32'hFFFF_FFFC;
         bus.lsu2wbu.dnpc      = $urandom & 32'hFFFF_FFFC;
         bus.lsu2wbu.rd_addr   = 5'($urandom);
         bus.lsu2wbu.wb        = 1'($urandom);
         bus.lsu2wbu.alu_res   = $urandom;
         bus.lsu2wbu.csr_addr  = pick_csr();
         bus.lsu2wbu.csr_we    = ($urandom % 4) == 0;
         bus.lsu2wbu.csr_wdata = $urandom;
         bus.lsu2wbu.ecall     = ($urandom % 8) == 0;
         bus.ifu2wbu_ready     = ($urandom % 4) != 0;
         rs1_addr  = 5'($urandom);
         rs2_addr  = 5'($urandom);
         csr_raddr = pick_csr();
      end
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] dnpc, input logic [4:0] rd,
                        input logic wb, input logic [31:0] alu, input logic [11:0] ca,
                        input logic cwe, input logic [31:0] cwd, input logic ec);
      int n = 0;
      while (!bus.wbu2lsu_ready && n < 50) begin
         step();
         n++;
      end
      chk("idle_wait", 32'(bus.wbu2lsu_ready), 32'd1);
      bus.lsu2wbu = '{valid: 1'b1, pc: pc, dnpc: dnpc, rd_addr: rd, wb: wb, alu_res: alu,
                      csr_addr: ca, csr_we: cwe, csr_wdata: cwd, ecall: ec};
      step();
      bus.lsu2wbu.valid = 1'b0;
   endtask

   initial begin
      bus.lsu2wbu = '0;
      bus.ifu2wbu_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      csr_raddr = 12'h300;
      step();
      chk("rst_ready", 32'(bus.wbu2lsu_ready), 32'd1);
      chk("rst_valid", 32'(bus.wbu2ifu_valid), 32'd0);
      chk("rst_npc", bus.wbu2ifu_npc, 32'h3000_0000);
      chk("rst_mstatus", csr_rdata, 32'h0000_1800);
      csr_raddr = 12'hB00;
      #1 chk("rst_mcycle", csr_rdata, 32'd1);

      // ALU write-back, then a dropped write to x0
      rs1_addr = 5'd5;
      csr_raddr = 12'hB02;
      issue(32'h3000_0000, 32'h3000_0004, 5'd5, 1'b1, 32'hDEAD_BEEF, 12'h0, 1'b0, 32'h0, 1'b0);
      chk("alu_commit_ready", 32'(bus.wbu2lsu_ready), 32'd0);
      chk("alu_commit_old", rs1_data, 32'd0);
      step();
      chk("alu_valid", 32'(bus.wbu2ifu_valid), 32'd1);
      chk("alu_npc", bus.wbu2ifu_npc, 32'h3000_0004);
      chk("alu_x5", rs1_data, 32'hDEAD_BEEF);
      chk("alu_minstret", csr_rdata, 32'd1);
      step();
      chk("alu_back_idle", 32'(bus.wbu2lsu_ready), 32'd1);
      rs2_addr = 5'd0;
      issue(32'h3000_0004, 32'h3000_0008, 5'd0, 1'b1, 32'h1234, 12'h0, 1'b0, 32'h0, 1'b0);
      step();
      step();
      chk("x0_zero", rs2_data, 32'd0);

      // ecall vectors to mtvec
      issue(32'h3000_0008, 32'h3000_000C, 5'd0, 1'b0, 32'h0, 12'h305, 1'b1, 32'h3000_0100, 1'b0);
      step();
      step();
      issue(32'h3000_0040, 32'h3000_0044, 5'd0, 1'b0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b1);
      step();
      chk("ecall_npc", bus.wbu2ifu_npc, 32'h3000_0100);
      csr_raddr = 12'h341;
      #1 chk("ecall_mepc", csr_rdata, 32'h3000_0040);
      csr_raddr = 12'h342;
      #1 chk("ecall_mcause", csr_rdata, 32'd11);
      step();

      // Trap write beats an explicit mcause write
      issue(32'h3000_0080, 32'h3000_0084, 5'd0, 1'b0, 32'h0, 12'h342, 1'b1, 32'd5, 1'b1);
      step();
      chk("prec_mcause", csr_rdata, 32'd11);
      chk("prec_npc", bus.wbu2ifu_npc, 32'h3000_0100);
      step();

      // IFU backpressure with a stray LSU valid
      bus.ifu2wbu_ready = 1'b0;
      rs1_addr = 5'd7;
      issue(32'h3000_00C0, 32'h3000_0200, 5'd0, 1'b0, 32'h0, 12'h0, 1'b0, 32'h0, 1'b0);
      step();
      bus.lsu2wbu = '{valid: 1'b1, pc: 32'h0, dnpc: 32'h0, rd_addr: 5'd7, wb: 1'b1,
                      alu_res: 32'h77, csr_addr: 12'h0, csr_we: 1'b0, csr_wdata: 32'h0,
                      ecall: 1'b0};
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.wbu2ifu_valid), 32'd1);
         chk("bp_npc", bus.wbu2ifu_npc, 32'h3000_0200);
         chk("bp_ready", 32'(bus.wbu2lsu_ready), 32'd0);
         step();
      end
      bus.lsu2wbu.valid = 1'b0;
      bus.ifu2wbu_ready = 1'b1;
      step();
      chk("bp_release_ready", 32'(bus.wbu2lsu_ready), 32'd1);
      chk("bp_release_valid", 32'(bus.wbu2ifu_valid), 32'd0);
      chk("bp_x7_untouched", rs1_data, 32'd0);

      // Register 17: dropped in RV32E, ordinary otherwise
      rs1_addr = 5'd17;
      rs2_addr = 5'd1;
      issue(32'h3000_0200, 32'h3000_0204, 5'd17, 1'b1, 32'd1, 12'h0, 1'b0, 32'h0, 1'b0);
      step();
      step();
`ifdef WBU_RVE_EN
      chk("rve_x17", rs1_data, 32'd0);
`else
      chk("rv32i_x17", rs1_data, 32'd1);
`endif
      chk("x1_zero", rs2_data, 32'd0);

      rnd = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) reset = 1'b1;
         if (i == 1502) reset = 1'b0;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
